operand_fetch_stage: RTL

- ID/EX pipeline stage between decode and execute in the RISC-V core. Drives the register file read indices and takes its two combinational read ports.
- Resolves RAW hazards: bypasses from EX and MEM, and inserts a one-cycle bubble on load-use.
- Registers the resolved operands plus control for the execute stage, using valid/ready handshakes on both sides.

---
 rtl/core_pkg.sv | 16 +
 rtl/operand_bypass.sv | 56 +++++
 rtl/operand_fetch_stage.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared constants and types for the core pipeline stages.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 16;

  // Source of a resolved operand, highest priority first.
  typedef enum logic [1:0] {
    FWD_ZERO = 2'd0,
    FWD_EX   = 2'd1,
    FWD_MEM  = 2'd2,
    FWD_RF   = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/operand_bypass.sv
// Per-source operand resolution: x0, EX bypass, MEM bypass or register file,
// plus the load-use hazard flag for this source.
module operand_bypass
  import core_pkg::*;
#(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int REG_AW = core_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] idx_i,
  input  logic              use_i,
  input  logic              ex_valid_i,
  input  logic              ex_we_i,
  input  logic              ex_is_load_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [XLEN-1:0]   ex_data_i,
  input  logic              mem_valid_i,
  input  logic              mem_we_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic [XLEN-1:0]   rf_data_i,
  output logic [XLEN-1:0]   operand_o,
  output fwd_sel_e          sel_o,
  output logic              hazard_o
);

  logic ex_match_s;
  logic mem_match_s;

  // Pick the operand source by priority and produce the hazard flag.
  always_comb begin
    ex_match_s  = ex_valid_i & ex_we_i & (ex_rd_i == idx_i) & ~ex_is_load_i;
    mem_match_s = mem_valid_i & mem_we_i & (mem_rd_i == idx_i);
    // A load in EX has no data yet; only a source that is really read stalls.
    hazard_o    = use_i & ex_valid_i & ex_we_i & ex_is_load_i &
                  (ex_rd_i != {REG_AW{1'b0}}) & (ex_rd_i == idx_i);

    if (idx_i == {REG_AW{1'b0}}) begin
      sel_o = FWD_ZERO;
    end else if (ex_match_s) begin
      sel_o = FWD_EX;
    end else if (mem_match_s) begin
      sel_o = FWD_MEM;
    end else begin
      sel_o = FWD_RF;
    end

    case (sel_o)
      FWD_ZERO: operand_o = {XLEN{1'b0}};
      FWD_EX:   operand_o = ex_data_i;
      FWD_MEM:  operand_o = mem_data_i;
      FWD_RF:   operand_o = rf_data_i;
      default:  operand_o = rf_data_i;
    endcase
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// ID/EX stage: reads the register file, resolves RAW hazards through EX/MEM
// bypassing or a load-use bubble, and registers operands toward execute.
module operand_fetch_stage
  import core_pkg::*;
#(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int REG_AW = core_pkg::REG_AW,
  parameter int CTRL_W = core_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic              in_is_load,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [REG_AW-1:0] rf_rd_idx1,
  output logic [REG_AW-1:0] rf_rd_idx2,
  input  logic [XLEN-1:0]   rf_reg1,
  input  logic [XLEN-1:0]   rf_reg2,
  input  logic              fwd_ex_valid,
  input  logic              fwd_ex_we,
  input  logic              fwd_ex_is_load,
  input  logic [REG_AW-1:0] fwd_ex_rd,
  input  logic [XLEN-1:0]   fwd_ex_data,
  input  logic              fwd_mem_valid,
  input  logic              fwd_mem_we,
  input  logic [REG_AW-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0]   fwd_mem_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [XLEN-1:0]   out_imm,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_rd_we,
  output logic              out_is_load,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              hazard_stall
);

  logic [XLEN-1:0]   op1_s, op2_s;
  logic              haz1_s, haz2_s, hazard_s, in_ready_s, capture_s;
  fwd_sel_e          sel1_unused_s, sel2_unused_s;

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d, op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              rd_we_q, rd_we_d, is_load_q, is_load_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  assign rf_rd_idx1 = in_rs1;
  assign rf_rd_idx2 = in_rs2;

  operand_bypass #(.XLEN(XLEN), .REG_AW(REG_AW)) u_byp1 (
    .idx_i(in_rs1), .use_i(in_use_rs1),
    .ex_valid_i(fwd_ex_valid), .ex_we_i(fwd_ex_we), .ex_is_load_i(fwd_ex_is_load),
    .ex_rd_i(fwd_ex_rd), .ex_data_i(fwd_ex_data),
    .mem_valid_i(fwd_mem_valid), .mem_we_i(fwd_mem_we),
    .mem_rd_i(fwd_mem_rd), .mem_data_i(fwd_mem_data),
    .rf_data_i(rf_reg1), .operand_o(op1_s), .sel_o(sel1_unused_s), .hazard_o(haz1_s)
  );

  operand_bypass #(.XLEN(XLEN), .REG_AW(REG_AW)) u_byp2 (
    .idx_i(in_rs2), .use_i(in_use_rs2),
    .ex_valid_i(fwd_ex_valid), .ex_we_i(fwd_ex_we), .ex_is_load_i(fwd_ex_is_load),
    .ex_rd_i(fwd_ex_rd), .ex_data_i(fwd_ex_data),
    .mem_valid_i(fwd_mem_valid), .mem_we_i(fwd_mem_we),
    .mem_rd_i(fwd_mem_rd), .mem_data_i(fwd_mem_data),
    .rf_data_i(rf_reg2), .operand_o(op2_s), .sel_o(sel2_unused_s), .hazard_o(haz2_s)
  );

  // Upstream handshake: accept when the output slot frees up and no hazard/flush.
  always_comb begin
    hazard_s     = haz1_s | haz2_s;
    in_ready_s   = (~valid_q | out_ready) & ~hazard_s & ~flush;
    capture_s    = in_valid & in_ready_s;
    in_ready     = in_ready_s;
    hazard_stall = in_valid & hazard_s;
  end

  // Next state: flush kills, capture loads all fields, drain clears valid, else hold.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    imm_d     = imm_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;
    is_load_d = is_load_q;
    ctrl_d    = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture_s) begin
      valid_d   = 1'b1;
      pc_d      = in_pc;
      op1_d     = op1_s;
      op2_d     = op2_s;
      imm_d     = in_imm;
      rd_d      = in_rd;
      rd_we_d   = in_rd_we;
      is_load_d = in_is_load;
      ctrl_d    = in_ctrl;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Pipeline registers toward execute.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      pc_q      <= {XLEN{1'b0}};
      op1_q     <= {XLEN{1'b0}};
      op2_q     <= {XLEN{1'b0}};
      imm_q     <= {XLEN{1'b0}};
      rd_q      <= {REG_AW{1'b0}};
      rd_we_q   <= 1'b0;
      is_load_q <= 1'b0;
      ctrl_q    <= {CTRL_W{1'b0}};
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      imm_q     <= imm_d;
      rd_q      <= rd_d;
      rd_we_q   <= rd_we_d;
      is_load_q <= is_load_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_op1     = op1_q;
  assign out_op2     = op2_q;
  assign out_imm     = imm_q;
  assign out_rd      = rd_q;
  assign out_rd_we   = rd_we_q;
  assign out_is_load = is_load_q;
  assign out_ctrl    = ctrl_q;

endmodule
